multi_button_processor: RTL and testbench



---
 rtl/multi_button_processor_pkg.sv | 29 ++
 rtl/multi_button_processor_if.sv | 22 ++
 rtl/button_channel.sv | 174 +++++++++++++++++
 rtl/multi_button_processor.sv | 53 +++++
 tb/tb_multi_button_processor.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/multi_button_processor_pkg.sv
// -----------------------------------------------------------------------------
// multi_button_processor_pkg
// Shared definitions for the pushbutton front end:
//   - 3-bit channel FSM state encoding (legacy-compatible localparams)
//   - event index constants used to address the per-event pulse generators
//   - cnt_width(): width of the per-channel hold/debounce counter
// -----------------------------------------------------------------------------
package multi_button_processor_pkg;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] DEBOUNCE = 3'd1;
   localparam logic [2:0] PRESSED  = 3'd2;
   localparam logic [2:0] LONG     = 3'd3;
   localparam logic [2:0] RELEASE  = 3'd4;

   localparam int EV_SHORT  = 0;
   localparam int EV_LONG   = 1;
   localparam int EV_REPEAT = 2;

   // The counter has to reach the largest of the three terminal values.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/multi_button_processor_if.sv
// -----------------------------------------------------------------------------
// multi_button_processor_if
// Bundles the raw button levels and the per-channel event/level outputs.
//   pushbutton_i : raw asynchronous button levels, active high
//   short_o      : short-press pulse per channel
//   long_o       : long-press pulse per channel
//   repeat_o     : auto-repeat pulse per channel
//   held_o       : debounced pressed level per channel
// Modports: master = pin/consumer side, slave = the button processor.
// -----------------------------------------------------------------------------
interface multi_button_processor_if #(
   parameter int NUM_BUTTONS = 4
);
   logic [NUM_BUTTONS-1:0] pushbutton_i;
   logic [NUM_BUTTONS-1:0] short_o;
   logic [NUM_BUTTONS-1:0] long_o;
   logic [NUM_BUTTONS-1:0] repeat_o;
   logic [NUM_BUTTONS-1:0] held_o;

   modport master (output pushbutton_i, input short_o, long_o, repeat_o, held_o);
   modport slave  (input pushbutton_i, output short_o, long_o, repeat_o, held_o);
endinterface

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One pushbutton channel: 2-FF synchroniser, press/release debounce FSM and
// fixed-width pulse generators for the short/long(/repeat) events.
// Ports:
//   clk_1khz  : 1 kHz clock
//   rst_i     : synchronous reset, active high
//   btn_raw   : raw asynchronous button level
//   short_o   : short-press pulse (PULSE_WIDTH cycles)
//   long_o    : long-press pulse (PULSE_WIDTH cycles)
//   repeat_o  : auto-repeat pulse; tied low unless
//               MULTI_BUTTON_PROCESSOR_AUTO_REPEAT_EN is defined
//   held_o    : debounced pressed level (PRESSED or LONG)
// -----------------------------------------------------------------------------
module button_channel
   import multi_button_processor_pkg::*;
#(
   parameter int DEBOUNCE_TIME   = 20,
   parameter int LONG_PRESS_TIME = 1500,
   parameter int REPEAT_PERIOD   = 250,
   parameter int PULSE_WIDTH     = 10
) (
   input  logic clk_1khz,
   input  logic rst_i,
   input  logic btn_raw,
   output logic short_o,
   output logic long_o,
   output logic repeat_o,
   output logic held_o
);

   localparam int CNT_W = cnt_width(DEBOUNCE_TIME, LONG_PRESS_TIME, REPEAT_PERIOD);
   localparam int PW_W  = $clog2(PULSE_WIDTH + 1);

   localparam logic [CNT_W-1:0] DT_C     = CNT_W'(DEBOUNCE_TIME);
   localparam logic [CNT_W-1:0] DT_M1    = CNT_W'(DEBOUNCE_TIME - 1);
   localparam logic [CNT_W-1:0] LPT_M1   = CNT_W'(LONG_PRESS_TIME - 1);
`ifdef MULTI_BUTTON_PROCESSOR_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] RP_M1    = CNT_W'(REPEAT_PERIOD - 1);
   localparam int               N_EV     = 3;
`else
   localparam int               N_EV     = 2;
`endif

   logic             sync_q1;
   logic             btn_s;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_EV-1:0]  fire;
   logic [N_EV-1:0]  pulse;

   // NOTE: sequential state always uses non-blocking assignments so every
   // flop samples the pre-edge value of its neighbours (the synchroniser
   // chain would collapse to one stage with blocking assignments).
   always_ff @(posedge clk_1khz) begin
      if (rst_i) begin
         sync_q1 <= 1'b0;
         btn_s   <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         sync_q1 <= btn_raw;
         btn_s   <= sync_q1;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fire    = '0;
      case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d = DEBOUNCE;
               cnt_d   = CNT_W'(1);
            end
         end
         DEBOUNCE: begin
            if (!btn_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DT_C) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            // Release is tested first so a release on the threshold edge
            // still counts as a short press.
            if (!btn_s) begin
               fire[EV_SHORT] = 1'b1;
               state_d        = RELEASE;
               cnt_d          = '0;
            end else if (cnt_q == LPT_M1) begin
               fire[EV_LONG] = 1'b1;
               state_d       = LONG;
               cnt_d         = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LONG: begin
            if (!btn_s) begin
               state_d = RELEASE;
               cnt_d   = '0;
            end
`ifdef MULTI_BUTTON_PROCESSOR_AUTO_REPEAT_EN
            else if (cnt_q == RP_M1) begin
               fire[EV_REPEAT] = 1'b1;
               cnt_d           = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         RELEASE: begin
            // Bounce during release only restarts the quiet-time count; it
            // can never re-enter DEBOUNCE.
            if (btn_s) begin
               cnt_d = '0;
            end else if (cnt_q == DT_M1) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // One pulse generator per event type. The output flop is set on the same
   // edge the event fires; a re-fire reloads the count so the pulse is
   // stretched without a gap.
   for (genvar e = 0; e < N_EV; e++) begin : g_pulse
      logic [PW_W-1:0] width_q;
      logic            pulse_q;

      always_ff @(posedge clk_1khz) begin
         if (rst_i) begin
            width_q <= '0;
            pulse_q <= 1'b0;
         end else if (fire[e]) begin
            width_q <= PW_W'(PULSE_WIDTH - 1);
            pulse_q <= 1'b1;
         end else if (width_q != '0) begin
            width_q <= width_q - PW_W'(1);
         end else begin
            pulse_q <= 1'b0;
         end
      end

      assign pulse[e] = pulse_q;
   end

   assign short_o = pulse[EV_SHORT];
   assign long_o  = pulse[EV_LONG];
`ifdef MULTI_BUTTON_PROCESSOR_AUTO_REPEAT_EN
   assign repeat_o = pulse[EV_REPEAT];
`else
   assign repeat_o = 1'b0;
`endif
   assign held_o  = (state_q == PRESSED) || (state_q == LONG);

endmodule

// File: rtl/multi_button_processor.sv
// -----------------------------------------------------------------------------
// multi_button_processor
// N-channel pushbutton front end: one independent button_channel per input.
// Ports:
//   clk_1khz : 1 kHz clock
//   rst_i    : synchronous reset, active high
//   btn_bus  : multi_button_processor_if.slave
//              (pushbutton_i in; short_o, long_o, repeat_o, held_o out)
// Optional feature: define MULTI_BUTTON_PROCESSOR_AUTO_REPEAT_EN to enable
// repeat_o events while a button is held past the long-press threshold.
// -----------------------------------------------------------------------------
module multi_button_processor
   import multi_button_processor_pkg::*;
#(
   parameter int NUM_BUTTONS     = 4,
   parameter int DEBOUNCE_TIME   = 20,
   parameter int LONG_PRESS_TIME = 1500,
   parameter int REPEAT_PERIOD   = 250,
   parameter int PULSE_WIDTH     = 10
) (
   input  logic                     clk_1khz,
   input  logic                     rst_i,
   multi_button_processor_if.slave  btn_bus
);

   logic [NUM_BUTTONS-1:0] short_v;
   logic [NUM_BUTTONS-1:0] long_v;
   logic [NUM_BUTTONS-1:0] repeat_v;
   logic [NUM_BUTTONS-1:0] held_v;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
      button_channel #(
         .DEBOUNCE_TIME   (DEBOUNCE_TIME),
         .LONG_PRESS_TIME (LONG_PRESS_TIME),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .PULSE_WIDTH     (PULSE_WIDTH)
      ) u_ch (
         .clk_1khz (clk_1khz),
         .rst_i    (rst_i),
         .btn_raw  (btn_bus.pushbutton_i[i]),
         .short_o  (short_v[i]),
         .long_o   (long_v[i]),
         .repeat_o (repeat_v[i]),
         .held_o   (held_v[i])
      );
   end

   assign btn_bus.short_o  = short_v;
   assign btn_bus.long_o   = long_v;
   assign btn_bus.repeat_o = repeat_v;
   assign btn_bus.held_o   = held_v;

endmodule

// File: tb/tb_multi_button_processor.sv
// -----------------------------------------------------------------------------
// tb_multi_button_processor
// Directed bench for multi_button_processor with default parameters.
// Cycle n of a scenario is the state seen after the n-th rising edge that
// follows the edge at which the stimulus was applied.
// -----------------------------------------------------------------------------
module tb_multi_button_processor;

   localparam int NB  = 4;
   localparam int DT  = 20;
   localparam int LPT = 1500;
   localparam int RP  = 250;
   localparam int PW  = 10;

   logic clk_1khz = 1'b0;
   logic rst_i    = 1'b1;

   multi_button_processor_if #(.NUM_BUTTONS(NB)) bus ();

   multi_button_processor #(
      .NUM_BUTTONS     (NB),
      .DEBOUNCE_TIME   (DT),
      .LONG_PRESS_TIME (LPT),
      .REPEAT_PERIOD   (RP),
      .PULSE_WIDTH     (PW)
   ) dut (
      .clk_1khz (clk_1khz),
      .rst_i    (rst_i),
      .btn_bus  (bus)
   );

   always #5 clk_1khz = ~clk_1khz;

   int n_checks = 0;
   int n_errors = 0;

   int cyc;
   int s_first [NB], l_first [NB], r_first [NB], h_first [NB];
   int s_rises [NB], l_rises [NB], r_rises [NB], h_rises [NB];
   int s_hi    [NB], l_hi    [NB];
   logic [NB-1:0] s_prev, l_prev, r_prev, h_prev;
   int both_hi;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_1khz);
      #1;
   endtask

   task automatic clear_obs();
      cyc     = 0;
      both_hi = 0;
      s_prev  = '0; l_prev = '0; r_prev = '0; h_prev = '0;
      for (int c = 0; c < NB; c++) begin
         s_first[c] = -1; l_first[c] = -1; r_first[c] = -1; h_first[c] = -1;
         s_rises[c] = 0;  l_rises[c] = 0;  r_rises[c] = 0;  h_rises[c] = 0;
         s_hi[c]    = 0;  l_hi[c]    = 0;
      end
   endtask

   // Advance one cycle and record rises/first-rise cycle/high-time per channel.
   task automatic tick();
      step();
      cyc++;
      for (int c = 0; c < NB; c++) begin
         if (bus.short_o[c] && !s_prev[c]) begin
            s_rises[c]++;
            if (s_first[c] < 0) s_first[c] = cyc;
         end
         if (bus.long_o[c] && !l_prev[c]) begin
            l_rises[c]++;
            if (l_first[c] < 0) l_first[c] = cyc;
         end
         if (bus.repeat_o[c] && !r_prev[c]) begin
            r_rises[c]++;
            if (r_first[c] < 0) r_first[c] = cyc;
         end
         if (bus.held_o[c] && !h_prev[c]) begin
            h_rises[c]++;
            if (h_first[c] < 0) h_first[c] = cyc;
         end
         if (bus.short_o[c]) s_hi[c]++;
         if (bus.long_o[c])  l_hi[c]++;
      end
      if (bus.short_o[0] && bus.long_o[3]) both_hi++;
      s_prev = bus.short_o;
      l_prev = bus.long_o;
      r_prev = bus.repeat_o;
      h_prev = bus.held_o;
   endtask

   task automatic do_reset(input string tag);
      bus.pushbutton_i = '0;
      rst_i = 1'b1;
      repeat (3) step();
      check(tag, int'({bus.short_o, bus.long_o, bus.repeat_o, bus.held_o}), 0);
      rst_i = 1'b0;
      clear_obs();
   endtask

   initial begin
      bus.pushbutton_i = '0;
      clear_obs();

      // 1: ch0 short press of 100 cycles.
      do_reset("reset_state");
      bus.pushbutton_i[0] = 1'b1;
      while (cyc < 140) begin
         tick();
         if (cyc == 100) bus.pushbutton_i[0] = 1'b0;
      end
      check("s1_held_rise",   h_first[0], DT + 3);
      check("s1_short_rise",  s_first[0], 103);
      check("s1_short_width", s_hi[0], PW);
      check("s1_no_long",     l_rises[0], 0);
      check("s1_no_repeat",   r_rises[0], 0);
      check("s1_held_end",    int'(bus.held_o[0]), 0);

      // 2: ch1 glitch shorter than the debounce time.
      do_reset("reset_s2");
      bus.pushbutton_i[1] = 1'b1;
      while (cyc < 60) begin
         tick();
         if (cyc == 10) bus.pushbutton_i[1] = 1'b0;
      end
      check("s2_no_held",  h_rises[1], 0);
      check("s2_no_short", s_rises[1], 0);
      check("s2_no_long",  l_rises[1], 0);

      // 3: ch2 held 2000 cycles.
      do_reset("reset_s3");
      bus.pushbutton_i[2] = 1'b1;
      while (cyc < 2060) begin
         tick();
         if (cyc == 2000) bus.pushbutton_i[2] = 1'b0;
      end
      check("s3_long_rise",  l_first[2], DT + LPT + 3);
      check("s3_long_width", l_hi[2], PW);
      check("s3_long_count", l_rises[2], 1);
      check("s3_no_short",   s_rises[2], 0);
`ifdef MULTI_BUTTON_PROCESSOR_AUTO_REPEAT_EN
      check("s3_repeat_rise",  r_first[2], DT + LPT + 3 + RP);
      check("s3_repeat_count", r_rises[2], 1);
`else
      check("s3_no_repeat", r_rises[2], 0);
`endif
      check("s3_held_end", int'(bus.held_o[2]), 0);

      // 4: ch0 release with bounce: low 3, high 2, then low.
      do_reset("reset_s4");
      bus.pushbutton_i[0] = 1'b1;
      while (cyc < 200) begin
         tick();
         if (cyc == 100) bus.pushbutton_i[0] = 1'b0;
         if (cyc == 103) bus.pushbutton_i[0] = 1'b1;
         if (cyc == 105) bus.pushbutton_i[0] = 1'b0;
      end
      check("s4_short_count", s_rises[0], 1);
      check("s4_short_rise",  s_first[0], 103);
      check("s4_short_width", s_hi[0], PW);
      check("s4_held_once",   h_rises[0], 1);

      // 5: ch0 short and ch3 long fire on the same edge.
      do_reset("reset_s5");
      bus.pushbutton_i[3] = 1'b1;
      while (cyc < 1560) begin
         tick();
         if (cyc == 1300) bus.pushbutton_i[0] = 1'b1;
         if (cyc == 1520) bus.pushbutton_i[0] = 1'b0;
      end
      check("s5_short0_rise",  s_first[0], DT + LPT + 3);
      check("s5_long3_rise",   l_first[3], DT + LPT + 3);
      check("s5_short0_width", s_hi[0], PW);
      check("s5_long3_width",  l_hi[3], PW);
      check("s5_overlap",      both_hi, PW);
      check("s5_no_long0",     l_rises[0], 0);
      check("s5_no_short3",    s_rises[3], 0);

      // 6: reset during a ch3 hold at cycle 800, button released in reset.
      do_reset("reset_s6");
      bus.pushbutton_i[3] = 1'b1;
      while (cyc < 799) tick();
      check("s6_held_before", int'(bus.held_o[3]), 1);
      rst_i = 1'b1;
      tick();
      check("s6_outputs_after_rst",
            int'({bus.short_o, bus.long_o, bus.repeat_o, bus.held_o}), 0);
      clear_obs();
      cyc = 800;
      while (cyc < 1700) begin
         tick();
         if (cyc == 802) bus.pushbutton_i[3] = 1'b0;
         if (cyc == 805) rst_i = 1'b0;
      end
      check("s6_no_long",  l_rises[3], 0);
      check("s6_no_short", s_rises[3], 0);
      check("s6_no_held",  h_rises[3], 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
